cpu_op_classifier: RTL and testbench

CPU_OP_CLASSIFIER -- requirements
Module: cpu_op_classifier

---
 rtl/cpu_op_classifier.sv | 174 +++++++++++++++++
 tb/tb_cpu_op_classifier.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_op_classifier.sv
// rtl/cpu_op_classifier.sv - classifies CPU requests as read/write hit/miss against a snooped tag store
// Optional macro CLASSIFIER_STATS_EN enables saturating hit/miss statistics counters.
module cpu_op_classifier #(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              inval_valid,
    input  logic [ADDR_W-1:0] inval_addr,
    output logic              op_valid,
    output logic [1:0]        op_code,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_LOOKUP = 2'b01;
    localparam logic [1:0] S_ISSUE  = 2'b10;

    logic [1:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hit_q, hit_d;
    logic              op_valid_q, op_valid_d;
    logic [1:0]        op_code_q, op_code_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];

    logic               accept;
    logic               lookup_en;
    logic               issue_en;
    logic               fill_en;
    logic               lookup_hit;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] inv_idx;
    logic [TAG_W-1:0]   inv_tag;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed IDLE -> LOOKUP -> ISSUE -> IDLE walk; the unused code recovers to IDLE
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = (req_valid) ? S_LOOKUP : S_IDLE;
            S_LOOKUP: state_d = S_ISSUE;
            S_ISSUE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake and per-phase enables for the datapath
    always_comb begin
        req_ready = (state_q == S_IDLE);
        accept    = req_valid && (state_q == S_IDLE);
        lookup_en = (state_q == S_LOOKUP);
        issue_en  = (state_q == S_ISSUE);
    end

    // Lookup, fill and snoop-invalidate logic for the tag store and request registers
    always_comb begin
        req_idx = addr_q[INDEX_W-1:0];
        req_tag = addr_q[ADDR_W-1:INDEX_W];
        inv_idx = inval_addr[INDEX_W-1:0];
        inv_tag = inval_addr[ADDR_W-1:INDEX_W];

        // A same-cycle invalidate of the exact line under lookup forces a miss
        lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                     && !(inval_valid && (inval_addr == addr_q));

        write_d = accept ? req_write : write_q;
        addr_d  = accept ? req_addr  : addr_q;
        hit_d   = lookup_en ? lookup_hit : hit_q;

        op_valid_d = lookup_en;
        op_code_d  = lookup_en ? {lookup_hit, write_q} : op_code_q;

        fill_en = issue_en && !hit_q;

        valid_d = valid_q;
        if (inval_valid && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag)) begin
            valid_d[inv_idx] = 1'b0;
        end
        // Fill is applied after the invalidate so it wins on the same line
        if (fill_en) begin
            valid_d[req_idx] = 1'b1;
        end

        tag_d = tag_q;
        if (fill_en) begin
            tag_d[req_idx] = req_tag;
        end
    end

    // Control and valid-bit registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_code_q  <= 2'b00;
            valid_q    <= '0;
        end else begin
            write_q    <= write_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            op_valid_q <= op_valid_d;
            op_code_q  <= op_code_d;
            valid_q    <= valid_d;
        end
    end

    // Tag storage: no reset, a tag is only consulted once its valid bit is set
    always_ff @(posedge clock) begin
        tag_q <= tag_d;
    end

    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;

`ifdef CLASSIFIER_STATS_EN
    logic [7:0] hit_count_q, hit_count_d;
    logic [7:0] miss_count_q, miss_count_d;

    // Saturating statistics, bumped on the cycle the op is presented
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (issue_en) begin
            if (hit_q && (hit_count_q != 8'hFF)) begin
                hit_count_d = hit_count_q + 8'd1;
            end
            if (!hit_q && (miss_count_q != 8'hFF)) begin
                miss_count_d = miss_count_q + 8'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_count_q  <= 8'd0;
            miss_count_q <= 8'd0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 8'd0;
    assign miss_count = 8'd0;
`endif

endmodule

// File: tb/tb_cpu_op_classifier.sv
// tb/tb_cpu_op_classifier.sv - directed self-checking bench for cpu_op_classifier
module tb_cpu_op_classifier;

    logic       clock;
    logic       resetn;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic       req_ready;
    logic       inval_valid;
    logic [7:0] inval_addr;
    logic       op_valid;
    logic [1:0] op_code;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int checks;
    int errors;

    cpu_op_classifier #(.ADDR_W(8), .INDEX_W(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .inval_valid (inval_valid),
        .inval_addr  (inval_addr),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Issue one request starting at a negedge; inv_phase 1 pulses inval during LOOKUP, 2 during ISSUE.
    // Returns op_valid in the three cycles after acceptance and op_code in the second.
    task automatic do_req(input logic wr, input logic [7:0] addr, input int inv_phase,
                          input logic [7:0] inv_addr, output logic v1, output logic v2,
                          output logic v3, output logic [1:0] code);
        int n;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_wait got 0 want 1");
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (inv_phase == 1) begin
            inval_valid = 1'b1;
            inval_addr  = inv_addr;
        end
        @(negedge clock);
        v1 = op_valid;
        @(posedge clock); #1;
        inval_valid = 1'b0;
        if (inv_phase == 2) begin
            inval_valid = 1'b1;
            inval_addr  = inv_addr;
        end
        @(negedge clock);
        v2   = op_valid;
        code = op_code;
        @(posedge clock); #1;
        inval_valid = 1'b0;
        @(negedge clock);
        v3 = op_valid;
    endtask

    task automatic standalone_inval(input logic [7:0] addr);
        inval_valid = 1'b1;
        inval_addr  = addr;
        @(posedge clock); #1;
        inval_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b want 0", op_valid); end
        checks++;
        if (op_code !== 2'b00) begin errors++; $display("FAIL reset_op_code got %b want 00", op_code); end
        checks++;
        if (hit_count !== 8'd0 || miss_count !== 8'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count);
        end
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read_fill;
        logic v1, v2, v3;
        logic [1:0] code;
        do_req(1'b0, 8'h14, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if ({v1, v2, v3} !== 3'b010) begin errors++; $display("FAIL read_latency got %b%b%b want 010", v1, v2, v3); end
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL read_miss_0x14 got %b want 00", code); end
        do_req(1'b0, 8'h14, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if ({v1, v2, v3} !== 3'b010) begin errors++; $display("FAIL read_latency2 got %b%b%b want 010", v1, v2, v3); end
        checks++;
        if (code !== 2'b10) begin errors++; $display("FAIL read_hit_0x14 got %b want 10", code); end
        checks++;
        if (op_code !== 2'b10) begin errors++; $display("FAIL op_code_hold got %b want 10", op_code); end
    endtask

    task automatic test_write_evict;
        logic v1, v2, v3;
        logic [1:0] code;
        do_req(1'b1, 8'h14, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b11) begin errors++; $display("FAIL write_hit_0x14 got %b want 11", code); end
        do_req(1'b1, 8'h24, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b01) begin errors++; $display("FAIL write_miss_0x24 got %b want 01", code); end
        do_req(1'b0, 8'h14, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL read_evicted_0x14 got %b want 00", code); end
    endtask

    task automatic test_inval;
        logic v1, v2, v3;
        logic [1:0] code;
        do_req(1'b0, 8'h37, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL fill_0x37 got %b want 00", code); end
        standalone_inval(8'h37);
        do_req(1'b0, 8'h37, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL inval_match_0x37 got %b want 00", code); end
        standalone_inval(8'h33);
        do_req(1'b0, 8'h37, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b10) begin errors++; $display("FAIL inval_nomatch_0x37 got %b want 10", code); end
    endtask

    task automatic test_inval_race;
        logic v1, v2, v3;
        logic [1:0] code;
        // line 3 holds 0x37 here; invalidate arrives with the lookup
        do_req(1'b0, 8'h37, 1, 8'h37, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL inval_during_lookup got %b want 00", code); end
        // the miss refilled 0x37; spec vector: inval 0x37 while 0x37 is filled
        standalone_inval(8'h37);
        do_req(1'b0, 8'h37, 2, 8'h37, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL fill_0x37_race got %b want 00", code); end
        do_req(1'b0, 8'h37, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b10) begin errors++; $display("FAIL fill_wins_0x37 got %b want 10", code); end
        // fill 0x33 over valid 0x37 while invalidating 0x37: fill must survive
        do_req(1'b0, 8'h33, 2, 8'h37, v1, v2, v3, code);
        checks++;
        if (code !== 2'b00) begin errors++; $display("FAIL evict_fill_0x33 got %b want 00", code); end
        do_req(1'b0, 8'h33, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (code !== 2'b10) begin errors++; $display("FAIL fill_wins_0x33 got %b want 10", code); end
    endtask

    task automatic test_reset_mid;
        logic v1, v2, v3;
        logic [1:0] code;
        logic seen;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h33;
        @(posedge clock); #1;
        req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || op_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async got ready=%b op_valid=%b want 1/0", req_ready, op_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (op_valid) seen = 1'b1;
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (op_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_op got %b want 0", seen); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", req_ready); end
        do_req(1'b0, 8'h33, 0, 8'h00, v1, v2, v3, code);
        checks++;
        if (v2 !== 1'b1 || code !== 2'b00) begin
            errors++; $display("FAIL mid_reset_miss got v=%b code=%b want 1/00", v2, code);
        end
    endtask

    task automatic test_stats;
        logic v1, v2, v3;
        logic [1:0] code;
        for (int i = 0; i < 300; i++) begin
            do_req(1'b0, 8'h33, 0, 8'h00, v1, v2, v3, code);
        end
        checks++;
        if (code !== 2'b10) begin errors++; $display("FAIL stats_last_hit got %b want 10", code); end
`ifdef CLASSIFIER_STATS_EN
        checks++;
        if (hit_count !== 8'd255) begin errors++; $display("FAIL hit_count_sat got %0d want 255", hit_count); end
        checks++;
        if (miss_count !== 8'd1) begin errors++; $display("FAIL miss_count got %0d want 1", miss_count); end
`else
        checks++;
        if (hit_count !== 8'd0) begin errors++; $display("FAIL hit_count_tied got %0d want 0", hit_count); end
        checks++;
        if (miss_count !== 8'd0) begin errors++; $display("FAIL miss_count_tied got %0d want 0", miss_count); end
`endif
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        resetn      = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = 8'h00;
        inval_valid = 1'b0;
        inval_addr  = 8'h00;
        test_reset();
        test_read_fill();
        test_write_evict();
        test_inval();
        test_inval_race();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
